// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage feeding the opcode decoder. One outstanding
//               req/gnt/rvalid fetch, instruction register, valid/ready to
//               decode, redirect with wrong-path discard.
//               Optional misaligned-redirect fault: IFU_MISALIGN_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  dec_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [6:0]            op_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic                  fetch_fault_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] c_NOP    = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] c_PC_INC = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e                r_state_q,   r_state_d;
    logic [DATA_WIDTH-1:0] r_pc_q,      r_pc_d;
    logic                  r_discard_q, r_discard_d;
    logic [DATA_WIDTH-1:0] r_instr_q,   r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_out_q,  r_pc_out_d;
    logic                  w_fault;

`ifdef IFU_MISALIGN_CHECK_EN
    logic                  r_fault_q,   r_fault_d;
    logic                  w_misaligned;

    assign w_misaligned  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_fault       = r_fault_q;
    assign fetch_fault_o = r_fault_q;
`else
    assign w_fault       = 1'b0;
`endif

    always_comb begin
        r_state_d   = r_state_q;
        r_pc_d      = r_pc_q;
        r_discard_d = r_discard_q;
        r_instr_d   = r_instr_q;
        r_pc_out_d  = r_pc_out_q;

        case (r_state_q)
            S_REQ: begin
                if (imem_gnt_i) begin
                    r_state_d = S_WAIT;
                end
                if (redirect_i) begin
                    r_pc_d      = redirect_pc_i;
                    r_discard_d = imem_gnt_i;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    // A redirect coinciding with the response drops the word just like a pending discard
                    if (r_discard_q || redirect_i) begin
                        r_discard_d = 1'b0;
                        r_state_d   = S_REQ;
                    end else begin
                        r_instr_d  = imem_rdata_i;
                        r_pc_out_d = r_pc_q;
                        r_state_d  = S_HOLD;
                    end
                end else if (redirect_i) begin
                    r_discard_d = 1'b1;
                end
                if (redirect_i) begin
                    r_pc_d = redirect_pc_i;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    r_pc_d    = redirect_pc_i;
                    r_state_d = S_REQ;
                end else if (dec_ready_i) begin
                    r_pc_d    = r_pc_q + c_PC_INC;
                    r_state_d = S_REQ;
                end
            end
            default: begin
                r_state_d = S_REQ;
            end
        endcase

`ifdef IFU_MISALIGN_CHECK_EN
        r_fault_d = r_fault_q;
        if (r_fault_q || w_misaligned) begin
            r_fault_d   = 1'b1;
            r_state_d   = S_HOLD;
            r_pc_d      = r_pc_q;
            r_discard_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= S_REQ;
            r_pc_q      <= RESET_PC;
            r_discard_q <= 1'b0;
            r_instr_q   <= c_NOP;
            r_pc_out_q  <= RESET_PC;
        end else begin
            r_state_q   <= r_state_d;
            r_pc_q      <= r_pc_d;
            r_discard_q <= r_discard_d;
            r_instr_q   <= r_instr_d;
            r_pc_out_q  <= r_pc_out_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_q <= 1'b0;
        end else begin
            r_fault_q <= r_fault_d;
        end
    end
`endif

    // Outputs are forced low while reset is sampled so nothing is issued in the reset cycle
    assign imem_req_o    = (r_state_q == S_REQ) && !reset;
    assign imem_addr_o   = r_pc_q;
    assign instr_valid_o = (r_state_q == S_HOLD) && !reset && !w_fault;
    assign instr_o       = r_instr_q;
    assign op_o          = r_instr_q[6:0];
    assign pc_o          = r_pc_out_q;
    assign pc_plus4_o    = r_pc_out_q + c_PC_INC;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit with a
//               behavioural instruction memory of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        dec_ready_i;
    logic [31:0] instr_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fetch_fault_o;
`endif

    int checks   = 0;
    int failures = 0;

    // memory model controls
    int          lat = 1;
    int          pend = 0;
    logic [31:0] pend_addr = '0;

    instruction_fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0040_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .dec_ready_i   (dec_ready_i),
        .instr_o       (instr_o),
        .op_o          (op_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .fetch_fault_o (fetch_fault_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: {addr[15:0], addr[15:0]} ^ 32'h33
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[15:0]} ^ 32'h0000_0033;
    endfunction

    // Memory responder: grants every request, answers lat cycles after grant
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(pend_addr);
                end
            end
            imem_gnt_i = imem_req_o;
            if (imem_gnt_i) begin
                pend      = lat;
                pend_addr = imem_addr_o;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        dec_ready_i   = 1'b0;

        // reset state
        step();
        step();
        check("rst_req",   {31'd0, imem_req_o},    32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o,                32'h0000_0013);
        check("rst_op",    {25'd0, op_o},          32'h13);
        reset = 1'b0;

        // 1. sequential fetch with 1-cycle memory
        dec_ready_i = 1'b1;
        step();
        check("t1_req0",  {31'd0, imem_req_o}, 32'd1);
        check("t1_addr0", imem_addr_o,         32'h0040_0000);
        step();
        check("t1_wait_req",   {31'd0, imem_req_o},    32'd0);
        check("t1_wait_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        check("t1_valid0", {31'd0, instr_valid_o}, 32'd1);
        check("t1_instr0", instr_o,                32'h0000_0033);
        check("t1_op0",    {25'd0, op_o},          32'h33);
        check("t1_pc0",    pc_o,                   32'h0040_0000);
        check("t1_pc4_0",  pc_plus4_o,             32'h0040_0004);
        step();
        check("t1_addr1", imem_addr_o, 32'h0040_0004);
        step();
        step();
        check("t1_instr1", instr_o,       32'h0004_0037);
        check("t1_op1",    {25'd0, op_o}, 32'h37);
        step();
        check("t1_addr2", imem_addr_o, 32'h0040_0008);
        step();
        step();
        check("t1_op2", {25'd0, op_o}, 32'h3B);
        check("t1_pc2", pc_o,          32'h0040_0008);

        // 2. decode stall for 5 cycles
        dec_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_valid", {31'd0, instr_valid_o}, 32'd1);
            check("t2_req",   {31'd0, imem_req_o},    32'd0);
            check("t2_instr", instr_o,                32'h0008_003B);
            check("t2_pc",    pc_o,                   32'h0040_0008);
        end
        dec_ready_i = 1'b1;
        lat         = 3;
        step();
        check("t2_addr_next", imem_addr_o,         32'h0040_000C);
        check("t2_req_next",  {31'd0, imem_req_o}, 32'd1);
        dec_ready_i = 1'b0;

        // 3. redirect in S_WAIT, stale response 3 cycles after grant
        step();
        check("t3_wait_req", {31'd0, imem_req_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0100;
        lat           = 1;
        step();
        redirect_i = 1'b0;
        check("t3_valid_a", {31'd0, instr_valid_o}, 32'd0);
        step();
        check("t3_valid_b", {31'd0, instr_valid_o}, 32'd0);
        check("t3_req_b",   {31'd0, imem_req_o},    32'd0);
        step();
        check("t3_valid_c", {31'd0, instr_valid_o}, 32'd0);
        check("t3_req_c",   {31'd0, imem_req_o},    32'd1);
        check("t3_addr",    imem_addr_o,            32'h0040_0100);
        step();
        check("t3_valid_d", {31'd0, instr_valid_o}, 32'd0);
        step();
        check("t3_valid_e", {31'd0, instr_valid_o}, 32'd1);
        check("t3_instr",   instr_o,                32'h0100_0133);
        check("t3_pc",      pc_o,                   32'h0040_0100);

        // 4. redirect together with dec_ready in S_HOLD
        dec_ready_i   = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0200;
        step();
        dec_ready_i = 1'b0;
        redirect_i  = 1'b0;
        check("t4_valid", {31'd0, instr_valid_o}, 32'd0);
        check("t4_addr",  imem_addr_o,            32'h0040_0200);
        step();
        step();
        check("t4_pc",    pc_o,    32'h0040_0200);
        check("t4_instr", instr_o, 32'h0200_0233);

        // 5. PC wrap-around
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        check("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        step();
        step();
        check("t5_pc_top",    pc_o,       32'hFFFF_FFFC);
        check("t5_pc4_top",   pc_plus4_o, 32'h0000_0000);
        check("t5_instr_top", instr_o,    32'hFFFC_FFCF);
        dec_ready_i = 1'b1;
        step();
        check("t5_addr_wrap", imem_addr_o, 32'h0000_0000);
        dec_ready_i = 1'b0;
        step();
        step();
        check("t5_pc_wrap",  pc_o,       32'h0000_0000);
        check("t5_pc4_wrap", pc_plus4_o, 32'h0000_0004);
        check("t5_op_wrap",  {25'd0, op_o}, 32'h33);

        // 6. misaligned redirect target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0102;
        step();
        redirect_i = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        check("t6_fault",  {31'd0, fetch_fault_o}, 32'd1);
        check("t6_valid",  {31'd0, instr_valid_o}, 32'd0);
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_req_parked", {31'd0, imem_req_o},    32'd0);
            check("t6_fault_stk",  {31'd0, fetch_fault_o}, 32'd1);
        end
        dec_ready_i = 1'b0;
        reset       = 1'b1;
        step();
        check("t6_fault_rst", {31'd0, fetch_fault_o}, 32'd0);
        reset = 1'b0;
        step();
        check("t6_req_after", {31'd0, imem_req_o}, 32'd1);
        check("t6_addr_after", imem_addr_o,        32'h0040_0000);
`else
        check("t6_req",   {31'd0, imem_req_o}, 32'd1);
        check("t6_addr",  imem_addr_o,         32'h0040_0102);
        step();
        step();
        check("t6_pc",    pc_o,    32'h0040_0102);
        check("t6_instr", instr_o, 32'h0102_0131);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
